// File: rtl/muldiv_unit_pkg.sv
// rtl/muldiv_unit_pkg.sv - opcode and state encodings shared by the mul/div unit
package muldiv_unit_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10
    } state_e;

    function automatic logic op_is_div(input op_e o);
        return (o == OP_DIV) || (o == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input op_e o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_unit_cond_neg.sv
// rtl/muldiv_unit_cond_neg.sv - conditional two's-complement negate
// Ports:
//   neg_i   1      negate when high
//   data_i  WIDTH  value in
//   data_o  WIDTH  neg_i ? -data_i : data_i
module cond_neg #(
    parameter int WIDTH = 32
) (
    input  logic             neg_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    assign data_o = neg_i ? ({WIDTH{1'b0}} - data_i) : data_i;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MIPS multiply/divide unit with HI/LO registers
// Ports:
//   Clk, Rst_n      clock, async active-low reset
//   start, op       launch MULT/MULTU/DIV/DIVU (sampled in IDLE only)
//   opA, opB        rs / rt operands; opA also feeds MTHI/MTLO
//   mthi, mtlo      write HI/LO from opA (IDLE only, dropped when start is high)
//   busy            high while an op is in CALC or FIX
//   done            one-cycle pulse when HI/LO were just written by an op
//   hi, lo          architectural HI/LO registers
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 is_div_q, is_div_d;
    logic                 sa_q, sa_d;
    logic                 sb_q, sb_d;
    logic                 dz_q, dz_d;
    // Multiplicand for MUL, divisor for DIV; the accumulator holds the other operand.
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    // Operand decode and absolute values at launch
    op_e              op_in;
    logic             in_signed, in_div, in_sa, in_sb;
    logic [WIDTH-1:0] abs_a, abs_b;

    assign op_in     = op_e'(op);
    assign in_signed = op_is_signed(op_in);
    assign in_div    = op_is_div(op_in);
    assign in_sa     = in_signed & opA[WIDTH-1];
    assign in_sb     = in_signed & opB[WIDTH-1];

    cond_neg #(.WIDTH(WIDTH)) u_abs_a (.neg_i(in_sa), .data_i(opA), .data_o(abs_a));
    cond_neg #(.WIDTH(WIDTH)) u_abs_b (.neg_i(in_sb), .data_i(opB), .data_o(abs_b));

    // One shift-add multiply step: add multiplicand into the upper half when the
    // current multiplier LSB is set, then shift the whole accumulator right.
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;

    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // One restoring divide step on {remainder, quotient}: the next dividend bit
    // shifts into the remainder while the quotient bit shifts in at the bottom.
    logic [WIDTH:0]       div_rem_sh;
    logic [WIDTH:0]       div_trial;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   div_next;

    assign div_rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_ge     = (div_rem_sh >= {1'b0, opnd_q});
    assign div_trial  = div_rem_sh - {1'b0, opnd_q};
    assign div_next   = {(div_ge ? div_trial[WIDTH-1:0] : div_rem_sh[WIDTH-1:0]),
                         acc_q[WIDTH-2:0], div_ge};

    // Result sign fix-up. With a zero divisor every trial subtract succeeds, so the
    // remainder ends up as |opA| and re-signing it restores the raw dividend.
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix, rem_fix;

    cond_neg #(.WIDTH(2*WIDTH)) u_fix_prod (.neg_i(sa_q ^ sb_q), .data_i(acc_q), .data_o(prod_fix));
    cond_neg #(.WIDTH(WIDTH))   u_fix_quot (.neg_i(sa_q ^ sb_q), .data_i(acc_q[WIDTH-1:0]), .data_o(quot_fix));
    cond_neg #(.WIDTH(WIDTH))   u_fix_rem  (.neg_i(sa_q), .data_i(acc_q[2*WIDTH-1:WIDTH]), .data_o(rem_fix));

    // State register and all registered outputs
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            dz_q     <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            dz_q     <= dz_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_CALC;
            S_CALC:  if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output next-values
    always_comb begin
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        dz_d     = dz_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_q == S_FIX);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d    = '0;
                    is_div_d = in_div;
                    sa_d     = in_sa;
                    sb_d     = in_sb;
                    dz_d     = (opB == {WIDTH{1'b0}});
                    opnd_d   = in_div ? abs_b : abs_a;
                    acc_d    = {{WIDTH{1'b0}}, (in_div ? abs_a : abs_b)};
                end else begin
                    if (mthi) hi_d = opA;
                    if (mtlo) lo_d = opA;
                end
            end
            S_CALC: begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q + 1'b1;
            end
            S_FIX: begin
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = dz_q ? {WIDTH{1'b1}} : quot_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
            default: ;
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;

    logic        Clk;
    logic        Rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        mthi;
    logic        mtlo;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_unit dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .start (start),
        .op    (op),
        .opA   (opA),
        .opB   (opB),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the unit in IDLE; launches the op immediately so
    // consecutive calls also exercise a start in the done cycle.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input bit disturb);
        int          cyc;
        bit          changed;
        logic [31:0] hi0, lo0;
        hi0     = hi;
        lo0     = lo;
        changed = 1'b0;
        start = 1'b1; op = o; opA = a; opB = b;
        @(posedge Clk);
        @(negedge Clk);
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0; opA = '0; opB = '0;
        check({tag, "_busy_e0"}, busy, 1);
        check({tag, "_done_e0"}, done, 0);
        cyc = 0;
        while (cyc < 100) begin
            @(posedge Clk);
            cyc++;
            @(negedge Clk);
            if (disturb && cyc == 5) begin
                start = 1'b1; mthi = 1'b1; mtlo = 1'b1; op = 2'b11;
                opA = 32'hDEADBEEF; opB = 32'h1;
            end
            if (disturb && cyc == 6) begin
                start = 1'b0; mthi = 1'b0; mtlo = 1'b0; opA = '0; opB = '0;
            end
            if (done) break;
            if (hi !== hi0 || lo !== lo0) changed = 1'b1;
        end
        check({tag, "_latency"}, cyc, 33);
        check({tag, "_hold"}, changed, 0);
        check({tag, "_busy_done"}, busy, 0);
        check({tag, "_hi"}, hi, exp[63:32]);
        check({tag, "_lo"}, lo, exp[31:0]);
    endtask

    initial begin : stim
        int done_cnt;
        Rst_n = 1'b0; start = 1'b0; op = 2'b00; opA = '0; opB = '0; mthi = 1'b0; mtlo = 1'b0;
        repeat (3) @(negedge Clk);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        Rst_n = 1'b1;
        @(negedge Clk);

        run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0);
        run_op("mult_m3x7", 2'b00, 32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFF_FFFFFFEB, 1'b0);
        run_op("mult_minsq", 2'b00, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b0);
        run_op("div_m7d2", 2'b10, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 1'b0);
        run_op("div_7dm2", 2'b10, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0);
        run_op("divu_100d7", 2'b11, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0);
        run_op("divu_dz", 2'b11, 32'h00001234, 32'h0, 64'h00001234_FFFFFFFF, 1'b0);
        run_op("div_dz_neg", 2'b10, 32'hFFFFFFFB, 32'h0, 64'hFFFFFFFB_FFFFFFFF, 1'b0);
        run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0);

        // MTHI / MTLO in IDLE
        mthi = 1'b1; opA = 32'hAAAAAAAA;
        @(negedge Clk);
        mthi = 1'b0;
        check("mthi_hi", hi, 32'hAAAAAAAA);
        check("mthi_lo", lo, 32'h80000000);
        mtlo = 1'b1; opA = 32'h55555555;
        @(negedge Clk);
        mtlo = 1'b0;
        check("mtlo_lo", lo, 32'h55555555);
        check("mtlo_hi", hi, 32'hAAAAAAAA);
        mthi = 1'b1; mtlo = 1'b1; opA = 32'h12345678;
        @(negedge Clk);
        mthi = 1'b0; mtlo = 1'b0;
        check("mtboth_hi", hi, 32'h12345678);
        check("mtboth_lo", lo, 32'h12345678);

        // mtlo together with start: the op wins, lo only ever takes the result
        mtlo = 1'b1;
        run_op("mtlo_start", 2'b01, 32'd3, 32'd5, 64'h00000000_0000000F, 1'b0);

        // start/mthi/mtlo while busy are ignored
        run_op("busy_ign", 2'b01, 32'd6, 32'd7, 64'h00000000_0000002A, 1'b1);

        // Reset mid-operation
        start = 1'b1; op = 2'b00; opA = 32'd3; opB = 32'd4;
        @(negedge Clk);
        start = 1'b0;
        repeat (9) @(negedge Clk);
        check("pre_rst_busy", busy, 1);
        Rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_hi", hi, 0);
        check("abort_lo", lo, 0);
        @(negedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (done) done_cnt++;
        end
        check("abort_no_done", done_cnt, 0);
        check("abort_hi_hold", hi, 0);

        run_op("recover", 2'b01, 32'd3, 32'd5, 64'h00000000_0000000F, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
